// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: request ports, tagged result and busy flag of the shared ALU
interface alu_share_ctrl_if;
   logic        req0_valid, req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_id;
   logic [31:0] rsp_data;
   logic        busy;
   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, busy
   );
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two-port round-robin shared ALU with iterative shifter and tagged one-cycle result pulse
module alu_share_ctrl #(
   parameter int SHIFT_STEP   = 4,
   parameter bit BARREL_SHIFT = 1'b0
) (
   input logic             clk,
   input logic             reset,
   alu_share_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [4:0] STEP = 5'(SHIFT_STEP);
   state_t      r_state, w_state_nxt;
   logic [3:0]  r_op, w_op;
   logic [31:0] r_acc, w_a, w_b;
   logic [4:0]  r_cnt, w_step;
   logic        r_id, r_rr_last;
   logic        w_idle, w_g0, w_g1, w_acc, w_iter;
   function automatic logic [31:0] f_shift(input logic [3:0] op, input logic [31:0] a, input logic [4:0] n);
      return op == 4'd5 ? a << n : op == 4'd6 ? a >> n : 32'($signed(a) >>> n);
   endfunction
   function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic lt, ltu;
      lt  = $signed(a) < $signed(b);
      ltu = a < b;
      case (op)
         4'd0:                return a + b;
         4'd1:                return a - b;
         4'd2:                return a & b;
         4'd3:                return a | b;
         4'd4:                return a ^ b;
         4'd5, 4'd6, 4'd7:    return f_shift(op, a, b[4:0]);
         4'd8, 4'd12:         return {31'd0, lt};
         4'd9, 4'd14:         return {31'd0, ltu};
         4'd10:               return {31'd0, a == b};
         4'd11:               return {31'd0, a != b};
         4'd13:               return {31'd0, !lt};
         default:             return {31'd0, !ltu};
      endcase
   endfunction
   always_comb begin
      w_idle      = r_state == IDLE;
      w_g0        = bus.req0_valid && (!bus.req1_valid || r_rr_last);
      w_g1        = bus.req1_valid && (!bus.req0_valid || !r_rr_last);
      w_acc       = w_idle && (w_g0 || w_g1);
      w_op        = w_g1 ? bus.req1_op : bus.req0_op;
      w_a         = w_g1 ? bus.req1_a : bus.req0_a;
      w_b         = w_g1 ? bus.req1_b : bus.req0_b;
      w_iter      = !BARREL_SHIFT && (w_op inside {4'd5, 4'd6, 4'd7}) && |w_b[4:0];
      w_step      = r_cnt >= STEP ? STEP : 5'd1;
      w_state_nxt = w_idle ? (w_acc ? (w_iter ? SHIFT : DONE) : IDLE) :
                    r_state == SHIFT ? (r_cnt == w_step ? DONE : SHIFT) : IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_id      <= 1'b0;
         r_rr_last <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc) begin
            r_op      <= w_op;
            r_id      <= w_g1;
            r_rr_last <= w_g1;
            r_acc     <= w_iter ? w_a : f_alu(w_op, w_a, w_b);
            r_cnt     <= w_b[4:0];
         end else if (r_state == SHIFT) begin
            r_acc <= f_shift(r_op, r_acc, w_step);
            r_cnt <= r_cnt - w_step;
         end
      end
   end
   assign bus.req0_ready = w_idle && w_g0;
   assign bus.req1_ready = w_idle && w_g1;
   assign bus.rsp_valid  = r_state == DONE;
   assign bus.rsp_id     = r_id;
   assign bus.rsp_data   = r_acc;
   assign bus.busy       = !w_idle;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed pins plus randomized two-port traffic against a cycle-level reference model
module tb_alu_share_ctrl;
   localparam int STEP = 4;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   alu_share_ctrl_if bus();
   alu_share_ctrl #(.SHIFT_STEP(STEP), .BARREL_SHIFT(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus));
   int n_vec = 0, n_err = 0;
   bit          mv[2];
   logic [3:0]  mop[2];
   logic [31:0] ma[2], mb[2];
   typedef struct packed {
      bit          p;
      logic [3:0]  op;
      logic [31:0] a, b, e;
      logic [7:0]  l;
   } vec_t;
   vec_t tv[10] = '{
      '{1'b0, 4'd0,  32'h5,        32'h3,        32'h8,        8'd1},
      '{1'b0, 4'd1,  32'h5,        32'h3,        32'h2,        8'd1},
      '{1'b1, 4'd7,  32'hF0000000, 32'h4,        32'hFF000000, 8'd2},
      '{1'b1, 4'd6,  32'h80000000, 32'd31,       32'h1,        8'd11},
      '{1'b1, 4'd5,  32'h1,        32'd32,       32'h1,        8'd1},
      '{1'b0, 4'd8,  32'hFFFFFFFF, 32'h1,        32'h1,        8'd1},
      '{1'b0, 4'd9,  32'hFFFFFFFF, 32'h1,        32'h0,        8'd1},
      '{1'b1, 4'd15, 32'h80000000, 32'h1,        32'h1,        8'd1},
      '{1'b1, 4'd13, 32'h80000000, 32'h1,        32'h0,        8'd1},
      '{1'b0, 4'd10, 32'h12345678, 32'h12345678, 32'h1,        8'd1}
   };
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh = int'(b[4:0]);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << sh;
         4'd6:  return a >> sh;
         4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
         4'd8:  return 32'($signed(a) < $signed(b));
         4'd9:  return 32'(a < b);
         4'd10: return 32'(a == b);
         4'd11: return 32'(a != b);
         4'd12: return 32'($signed(a) < $signed(b));
         4'd13: return 32'($signed(a) >= $signed(b));
         4'd14: return 32'(a < b);
         default: return 32'(a >= b);
      endcase
   endfunction
   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
      int n = int'(b[4:0]);
      return (op >= 4'd5 && op <= 4'd7) ? 1 + n / STEP + n % STEP : 1;
   endfunction
   task automatic drive();
      bus.req0_valid = mv[0]; bus.req0_op = mop[0]; bus.req0_a = ma[0]; bus.req0_b = mb[0];
      bus.req1_valid = mv[1]; bus.req1_op = mop[1]; bus.req1_a = ma[1]; bus.req1_b = mb[1];
   endtask
   task automatic new_req(input int q);
      mv[q]  = ($urandom % 4) != 0;
      mop[q] = 4'($urandom);
      ma[q]  = $urandom;
      mb[q]  = ($urandom % 4 == 0) ? ma[q] : $urandom;
   endtask
   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_data", bus.rsp_data, 0);
      chk("rst_id", 32'(bus.rsp_id), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask
   task automatic wait_ready(input bit p, output bit got);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = p ? bus.req1_ready : bus.req0_ready;
      end
      chk("accept_seen", 32'(got), 1);
   endtask
   task automatic run_one(input bit p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output bit id, output int lat);
      bit got;
      mv[p] = 1'b1; mop[p] = op; ma[p] = a; mb[p] = b;
      drive();
      wait_ready(p, got);
      @(posedge clk);
      #1 mv[p] = 1'b0; ma[p] = ~a; mb[p] = $urandom;
      drive();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 40);
      d  = bus.rsp_data;
      id = bus.rsp_id;
   endtask
   task automatic arb_run(input int n, input bit alt, input string tag);
      int pq[$], cq[$];
      for (int k = 0; k < 10 * n && pq.size() < n; k++) begin
         @(negedge clk);
         if (bus.req0_ready) begin pq.push_back(0); cq.push_back(k); end
         if (bus.req1_ready) begin pq.push_back(1); cq.push_back(k); end
      end
      chk({tag, "_count"}, 32'(pq.size()), 32'(n));
      foreach (pq[i]) begin
         chk($sformatf("%s_port%0d", tag, i), 32'(pq[i]), alt ? 32'(i % 2) : 0);
         if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 32'(cq[i] - cq[i-1]), 2);
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [31:0] d;
      bit id, got, g0, g1, idle;
      int lat, idle_at, rsp_at, p;
      bit rr_last, exp_id;
      logic [31:0] exp_d;
      mv = '{1'b0, 1'b0}; mop = '{4'd0, 4'd0}; ma = '{32'd0, 32'd0}; mb = '{32'd0, 32'd0};
      drive();
      do_reset();
      foreach (tv[i]) begin
         run_one(tv[i].p, tv[i].op, tv[i].a, tv[i].b, d, id, lat);
         chk($sformatf("dir%0d_data", i), d, tv[i].e);
         chk($sformatf("dir%0d_id", i), 32'(id), 32'(tv[i].p));
         chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(tv[i].l));
         chk($sformatf("model%0d_data", i), ref_res(tv[i].op, tv[i].a, tv[i].b), tv[i].e);
         chk($sformatf("model%0d_lat", i), 32'(ref_lat(tv[i].op, tv[i].b)), 32'(tv[i].l));
      end
      do_reset();
      mv = '{1'b1, 1'b1}; mop = '{4'd0, 4'd0}; ma = '{32'd100, 32'd200}; mb = '{32'd1, 32'd2};
      drive();
      arb_run(8, 1'b1, "arb_both");
      mv[1] = 1'b0;
      drive();
      arb_run(4, 1'b0, "arb_p0");
      mv = '{1'b0, 1'b0};
      drive();
      repeat (3) @(posedge clk);
      mv[0] = 1'b1; mop[0] = 4'd5; ma[0] = 32'h1; mb[0] = 32'd31;
      drive();
      wait_ready(1'b0, got);
      @(posedge clk);
      #1 mv[0] = 1'b0;
      drive();
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid", 32'(bus.rsp_valid), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      mv = '{1'b1, 1'b1}; mop = '{4'd0, 4'd0}; ma = '{32'd7, 32'd9}; mb = '{32'd1, 32'd1};
      drive();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      arb_run(2, 1'b1, "post_rst");
      mv = '{1'b0, 1'b0};
      drive();
      do_reset();
      idle_at = 0; rsp_at = -1; rr_last = 1'b1; exp_id = 1'b0; exp_d = '0;
      new_req(0); new_req(1);
      drive();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         idle = cyc >= idle_at;
         g0 = idle && mv[0] && (!mv[1] || rr_last);
         g1 = idle && mv[1] && (!mv[0] || !rr_last);
         chk("rnd_ready0", 32'(bus.req0_ready), 32'(g0));
         chk("rnd_ready1", 32'(bus.req1_ready), 32'(g1));
         chk("rnd_valid", 32'(bus.rsp_valid), 32'(cyc == rsp_at));
         chk("rnd_busy", 32'(bus.busy), 32'(!idle));
         if (cyc == rsp_at) begin
            chk("rnd_id", 32'(bus.rsp_id), 32'(exp_id));
            chk("rnd_data", bus.rsp_data, exp_d);
         end
         @(posedge clk);
         #1;
         if (g0 || g1) begin
            p       = g1 ? 1 : 0;
            exp_d   = ref_res(mop[p], ma[p], mb[p]);
            exp_id  = g1;
            lat     = ref_lat(mop[p], mb[p]);
            rsp_at  = cyc + lat;
            idle_at = cyc + lat + 1;
            rr_last = g1;
            new_req(p);
         end
         for (int q = 0; q < 2; q++) if (!mv[q]) new_req(q);
         drive();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
